// File: rtl/bram_sdp_be_pkg.sv
// rtl/bram_sdp_be_pkg.sv - shared state encoding, collision-mode constants and lane-count helper for bram_sdp_be
package bram_sdp_be_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_sdp_be_if.sv
// rtl/bram_sdp_be_if.sv - write/read/status bundle of bram_sdp_be; BRAM_SDP_COLLISION_FLAG_EN adds rd_collision
interface bram_sdp_be_if
    import bram_sdp_be_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
);
    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                     we;
    logic [NUM_BYTES-1:0]     wr_be;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    d_in;
    logic                     rd_en;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    d_out;
    logic                     rd_valid;
    logic                     init_busy;

`ifdef BRAM_SDP_COLLISION_FLAG_EN
    logic                     rd_collision;

    modport master (
        output we, wr_be, wr_addr, d_in, rd_en, rd_addr,
        input  d_out, rd_valid, init_busy, rd_collision
    );
    modport slave (
        input  we, wr_be, wr_addr, d_in, rd_en, rd_addr,
        output d_out, rd_valid, init_busy, rd_collision
    );
`else
    modport master (
        output we, wr_be, wr_addr, d_in, rd_en, rd_addr,
        input  d_out, rd_valid, init_busy
    );
    modport slave (
        input  we, wr_be, wr_addr, d_in, rd_en, rd_addr,
        output d_out, rd_valid, init_busy
    );
`endif

endinterface

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - read data/valid delay line of 1 or 2 cycles; BRAM_SDP_COLLISION_FLAG_EN carries the collision bit
module bram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_go,
    input  logic [DATA_WIDTH-1:0] rd_word,
`ifdef BRAM_SDP_COLLISION_FLAG_EN
    input  logic                  collide,
    output logic                  rd_collision,
`endif
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  rd_valid
);

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_word;
`ifdef BRAM_SDP_COLLISION_FLAG_EN
    logic                  s_coll;
`endif

    generate
        if (RD_LATENCY == 2) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_valid <= 1'b0;
                    s_word  <= '0;
`ifdef BRAM_SDP_COLLISION_FLAG_EN
                    s_coll  <= 1'b0;
`endif
                end else begin
                    s_valid <= rd_go;
                    if (rd_go) s_word <= rd_word;
`ifdef BRAM_SDP_COLLISION_FLAG_EN
                    s_coll  <= rd_go && collide;
`endif
                end
            end
        end else begin : g_direct
            assign s_valid = rd_go;
            assign s_word  = rd_word;
`ifdef BRAM_SDP_COLLISION_FLAG_EN
            assign s_coll  = rd_go && collide;
`endif
        end
    endgenerate

    // d_out only moves when a read completes, so it holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out        <= '0;
            rd_valid     <= 1'b0;
`ifdef BRAM_SDP_COLLISION_FLAG_EN
            rd_collision <= 1'b0;
`endif
        end else begin
            rd_valid <= s_valid;
            if (s_valid) d_out <= s_word;
`ifdef BRAM_SDP_COLLISION_FLAG_EN
            rd_collision <= s_valid && s_coll;
`endif
        end
    end

endmodule

// File: rtl/bram_sdp_be.sv
// rtl/bram_sdp_be.sv - simple-dual-port RAM with byte enables, post-reset clear, 1/2-cycle reads; BRAM_SDP_COLLISION_FLAG_EN adds rd_collision
module bram_sdp_be
    import bram_sdp_be_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int RD_LATENCY    = 1,
    parameter int WRITE_FIRST   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    bram_sdp_be_if.slave  bus
);

    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] CLR_LAST = {1'b0, {ADDRESS_WIDTH{1'b1}}};

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("bram_sdp_be: RD_LATENCY must be 1 or 2");
        end
        if (WRITE_FIRST != RD_FIRST && WRITE_FIRST != WR_FIRST) begin : g_bad_mode
            $error("bram_sdp_be: WRITE_FIRST must be 0 or 1");
        end
        if (NUM_BYTES * BYTE_WIDTH != DATA_WIDTH) begin : g_bad_width
            $error("bram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    state_t                   state, state_nxt;
    logic [ADDRESS_WIDTH:0]   clr_cnt, clr_cnt_nxt;
    logic                     clr_we;
    logic                     wr_go, rd_go, collide;
    logic [DATA_WIDTH-1:0]    old_word, rd_word;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // one word zeroed per cycle; the extra counter bit keeps the final compare wrap-free
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
            end
            default: ;
        endcase
    end

    assign bus.init_busy = (state == ST_CLEAR);
    assign wr_go   = (state == ST_RUN) && bus.we;
    assign rd_go   = (state == ST_RUN) && bus.rd_en;
    assign collide = wr_go && rd_go && (bus.wr_addr == bus.rd_addr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt[ADDRESS_WIDTH-1:0]] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i])
                    mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.d_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign old_word = mem[bus.rd_addr];

    // write-first forwards the enabled lanes of the in-flight write into the read
    always_comb begin
        rd_word = old_word;
        if (WRITE_FIRST != RD_FIRST && collide) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i])
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.d_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    bram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_go        (rd_go),
        .rd_word      (rd_word),
`ifdef BRAM_SDP_COLLISION_FLAG_EN
        .collide      (collide),
        .rd_collision (bus.rd_collision),
`endif
        .d_out        (bus.d_out),
        .rd_valid     (bus.rd_valid)
    );

endmodule

// File: tb/tb_bram_sdp_be.sv
// tb/tb_bram_sdp_be.sv - self-checking bench: read-first/latency-1 and write-first/latency-2 instances; honours BRAM_SDP_COLLISION_FLAG_EN
module tb_bram_sdp_be;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_sdp_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDRESS_WIDTH(AW)) if0 (), if1 ();

    bram_sdp_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDRESS_WIDTH(AW), .RD_LATENCY(1), .WRITE_FIRST(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    bram_sdp_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDRESS_WIDTH(AW), .RD_LATENCY(2), .WRITE_FIRST(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int          n_vec = 0;
    int          n_err = 0;
    bit          running = 1'b0;
    logic [31:0] model [DEPTH];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic step(input bit w, input logic [3:0] be, input logic [7:0] wa, input logic [31:0] din,
                        input bit r, input logic [7:0] ra);
        if0.we = w; if0.wr_be = be; if0.wr_addr = wa; if0.d_in = din; if0.rd_en = r; if0.rd_addr = ra;
        if1.we = w; if1.wr_be = be; if1.wr_addr = wa; if1.d_in = din; if1.rd_en = r; if1.rd_addr = ra;
        @(posedge clk);
        #1;
        if (running && w) model[wa] = merge(model[wa], din, be);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        n_vec++; if (if0.init_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy0 got %b want 1", if0.init_busy); end
        n_vec++; if (if1.init_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy1 got %b want 1", if1.init_busy); end
        n_vec++; if (if0.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid0 got %b want 0", if0.rd_valid); end
        n_vec++; if (if1.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid1 got %b want 0", if1.rd_valid); end
        n_vec++; if (if0.d_out !== 32'h0) begin n_err++; $display("FAIL reset_dout0 got %h want 0", if0.d_out); end
        n_vec++; if (if1.d_out !== 32'h0) begin n_err++; $display("FAIL reset_dout1 got %h want 0", if1.d_out); end
    endtask

    // release reset and count edges until init_busy drops, optionally poking requests meanwhile
    task automatic test_clear(input bit pulse);
        int n, n0, n1;
        n = 0; n0 = 0; n1 = 0;
        running = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[a] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        while ((if0.init_busy || if1.init_busy) && n < 1000) begin
            if (pulse && (n % 5 == 0)) step(1'b1, 4'hF, 8'(n % 16), 32'hDEAD_BEEF, 1'b1, 8'(n % 16));
            else idle();
            n++;
            if (!if0.init_busy && n0 == 0) n0 = n;
            if (!if1.init_busy && n1 == 0) n1 = n;
            n_vec++;
            if (if0.rd_valid !== 1'b0 || if1.rd_valid !== 1'b0) begin
                n_err++; $display("FAIL clear_valid step %0d got %b/%b want 0/0", n, if0.rd_valid, if1.rd_valid);
            end
        end
        n_vec++; if (n0 != DEPTH) begin n_err++; $display("FAIL clear_len0 got %0d want %0d", n0, DEPTH); end
        n_vec++; if (n1 != DEPTH) begin n_err++; $display("FAIL clear_len1 got %0d want %0d", n1, DEPTH); end
        running = 1'b1;
    endtask

    task automatic test_clear_readback();
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(a));
            n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'h0) begin
                n_err++; $display("FAIL readback0 addr %0d got %b/%h want 1/0", a, if0.rd_valid, if0.d_out); end
            n_vec++; if (if1.rd_valid !== (a != 0) || if1.d_out !== 32'h0) begin
                n_err++; $display("FAIL readback1 addr %0d got %b/%h want %b/0", a, if1.rd_valid, if1.d_out, a != 0); end
        end
        idle();
        n_vec++; if (if1.rd_valid !== 1'b1 || if1.d_out !== 32'h0) begin
            n_err++; $display("FAIL readback1_last got %b/%h want 1/0", if1.rd_valid, if1.d_out); end
        n_vec++; if (if0.rd_valid !== 1'b0) begin n_err++; $display("FAIL readback0_drop got %b want 0", if0.rd_valid); end
        idle();
    endtask

    task automatic test_byte_enable();
        step(1'b1, 4'b1111, 8'd5, 32'hAABBCCDD, 1'b0, 8'd0);
        step(1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b0, 8'd0);
        step(1'b0, 4'b0000, 8'd0, 32'h0, 1'b1, 8'd5);
        n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'hAA22CC44) begin
            n_err++; $display("FAIL byte_en0 got %b/%h want 1/aa22cc44", if0.rd_valid, if0.d_out); end
        n_vec++; if (if1.rd_valid !== 1'b0) begin n_err++; $display("FAIL byte_en1_early got %b want 0", if1.rd_valid); end
        idle();
        n_vec++; if (if1.rd_valid !== 1'b1 || if1.d_out !== 32'hAA22CC44) begin
            n_err++; $display("FAIL byte_en1 got %b/%h want 1/aa22cc44", if1.rd_valid, if1.d_out); end
        n_vec++; if (if0.rd_valid !== 1'b0) begin n_err++; $display("FAIL byte_en0_drop got %b want 0", if0.rd_valid); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 8'(i), 32'h10 + 32'(i), 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'(k));
            n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'h10 + 32'(k)) begin
                n_err++; $display("FAIL b2b0 k=%0d got %b/%h want 1/%h", k, if0.rd_valid, if0.d_out, 32'h10 + 32'(k)); end
            if (k == 0) begin
                n_vec++; if (if1.rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b1_first got %b want 0", if1.rd_valid); end
            end else begin
                n_vec++; if (if1.rd_valid !== 1'b1 || if1.d_out !== 32'h0F + 32'(k)) begin
                    n_err++; $display("FAIL b2b1 k=%0d got %b/%h want 1/%h", k, if1.rd_valid, if1.d_out, 32'h0F + 32'(k)); end
            end
        end
        idle();
        n_vec++; if (if1.rd_valid !== 1'b1 || if1.d_out !== 32'h13) begin
            n_err++; $display("FAIL b2b1_last got %b/%h want 1/13", if1.rd_valid, if1.d_out); end
        n_vec++; if (if0.rd_valid !== 1'b0 || if0.d_out !== 32'h13) begin
            n_err++; $display("FAIL b2b0_hold got %b/%h want 0/13", if0.rd_valid, if0.d_out); end
        idle();
        n_vec++; if (if1.rd_valid !== 1'b0 || if1.d_out !== 32'h13) begin
            n_err++; $display("FAIL b2b1_hold got %b/%h want 0/13", if1.rd_valid, if1.d_out); end
    endtask

    task automatic test_collision();
        step(1'b1, 4'b0011, 8'd9, 32'hFFFFFFFF, 1'b1, 8'd9);
        n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'h0) begin
            n_err++; $display("FAIL coll_rdfirst got %b/%h want 1/00000000", if0.rd_valid, if0.d_out); end
`ifdef BRAM_SDP_COLLISION_FLAG_EN
        n_vec++; if (if0.rd_collision !== 1'b1) begin n_err++; $display("FAIL coll_flag0 got %b want 1", if0.rd_collision); end
`endif
        step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd9);
        n_vec++; if (if1.rd_valid !== 1'b1 || if1.d_out !== 32'h0000FFFF) begin
            n_err++; $display("FAIL coll_wrfirst got %b/%h want 1/0000ffff", if1.rd_valid, if1.d_out); end
        n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'h0000FFFF) begin
            n_err++; $display("FAIL coll_after0 got %b/%h want 1/0000ffff", if0.rd_valid, if0.d_out); end
`ifdef BRAM_SDP_COLLISION_FLAG_EN
        n_vec++; if (if1.rd_collision !== 1'b1) begin n_err++; $display("FAIL coll_flag1 got %b want 1", if1.rd_collision); end
        n_vec++; if (if0.rd_collision !== 1'b0) begin n_err++; $display("FAIL coll_flag0_after got %b want 0", if0.rd_collision); end
`endif
        idle();
        n_vec++; if (if1.d_out !== 32'h0000FFFF) begin n_err++; $display("FAIL coll_after1 got %h want 0000ffff", if1.d_out); end
`ifdef BRAM_SDP_COLLISION_FLAG_EN
        n_vec++; if (if1.rd_collision !== 1'b0) begin n_err++; $display("FAIL coll_flag1_after got %b want 0", if1.rd_collision); end
`endif
        idle();
    endtask

    task automatic test_random();
        bit          w, r, ev, ec, pv, pc;
        logic [3:0]  be;
        logic [7:0]  wa, ra;
        logic [31:0] din, e0, e1, p1, h0, h1;
        pv = 1'b0; pc = 1'b0; p1 = '0;
        h0 = model[9]; h1 = model[9];
        for (int t = 0; t < 400; t++) begin
            w   = ($urandom_range(3) != 0);
            r   = ($urandom_range(3) != 0);
            be  = 4'($urandom);
            din = $urandom;
            wa  = 8'(16 + $urandom_range(7));
            ra  = 8'(16 + $urandom_range(7));
            ev  = r;
            ec  = w && r && (wa == ra);
            e0  = model[ra];
            e1  = ec ? merge(model[ra], din, be) : model[ra];
            step(w, be, wa, din, r, ra);
            if (ev) h0 = e0;
            if (pv) h1 = p1;
            n_vec++; if (if0.rd_valid !== ev || if0.d_out !== h0) begin
                n_err++; $display("FAIL rand0 t=%0d got %b/%h want %b/%h", t, if0.rd_valid, if0.d_out, ev, h0); end
            n_vec++; if (if1.rd_valid !== pv || if1.d_out !== h1) begin
                n_err++; $display("FAIL rand1 t=%0d got %b/%h want %b/%h", t, if1.rd_valid, if1.d_out, pv, h1); end
`ifdef BRAM_SDP_COLLISION_FLAG_EN
            if (ev) begin
                n_vec++; if (if0.rd_collision !== ec) begin n_err++; $display("FAIL rand_coll0 t=%0d got %b want %b", t, if0.rd_collision, ec); end
            end
            if (pv) begin
                n_vec++; if (if1.rd_collision !== pc) begin n_err++; $display("FAIL rand_coll1 t=%0d got %b want %b", t, if1.rd_collision, pc); end
            end
`endif
            pv = ev; pc = ec; p1 = e1;
        end
        idle();
        if (pv) h1 = p1;
        n_vec++; if (if1.rd_valid !== pv || if1.d_out !== h1) begin
            n_err++; $display("FAIL rand1_tail got %b/%h want %b/%h", if1.rd_valid, if1.d_out, pv, h1); end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5);
        n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'hAA22CC44) begin
            n_err++; $display("FAIL pre_reset_read got %b/%h want 1/aa22cc44", if0.rd_valid, if0.d_out); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (if0.rd_valid !== 1'b0 || if0.d_out !== 32'h0) begin
            n_err++; $display("FAIL async_reset0 got %b/%h want 0/0", if0.rd_valid, if0.d_out); end
        n_vec++; if (if1.d_out !== 32'h0 || if1.init_busy !== 1'b1) begin
            n_err++; $display("FAIL async_reset1 got %h/%b want 0/1", if1.d_out, if1.init_busy); end
        running = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) idle();
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (if0.init_busy !== 1'b1 || if0.rd_valid !== 1'b0 || if0.d_out !== 32'h0) begin
            n_err++; $display("FAIL mid_clear_reset got %b/%b/%h want 1/0/0", if0.init_busy, if0.rd_valid, if0.d_out); end
        test_clear(1'b0);
        step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 8'd5);
        n_vec++; if (if0.rd_valid !== 1'b1 || if0.d_out !== 32'h0) begin
            n_err++; $display("FAIL recleared_read got %b/%h want 1/0", if0.rd_valid, if0.d_out); end
        idle();
        n_vec++; if (if1.rd_valid !== 1'b1 || if1.d_out !== 32'h0) begin
            n_err++; $display("FAIL recleared_read1 got %b/%h want 1/0", if1.rd_valid, if1.d_out); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear(1'b1);
        test_clear_readback();
        test_byte_enable();
        test_back_to_back();
        test_collision();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
